// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller link (poll transmitter and response receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: receiver FSM state enum, link timing constants for a 50 MHz core clock,
// and a saturating increment helper for the 16-bit phase counter.
package n64_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        LOW,
        HIGH,
        DONE,
        ERROR
    } state_t;

    // Nominal bit cell on the wire.
    localparam int N64_BIT_PERIOD_US = 4;

    // Tick constants for a 50 MHz clock (50 ticks per microsecond).
    localparam int N64_CLK_MHZ           = 50;
    localparam int N64_BIT_THRESH        = 2 * N64_CLK_MHZ;   // 2 us
    localparam int N64_PHASE_TIMEOUT     = 8 * N64_CLK_MHZ;   // 8 us
    localparam int N64_START_TIMEOUT     = 20 * N64_CLK_MHZ;  // 20 us
    localparam int N64_NUM_BITS          = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/n64_sync_edge.sv
// Two-flop synchronizer for the open-drain N64 line with rise/fall pulse outputs.
// Latency: rise/fall valid 2 cycles after the line changes (visible to the consumer's next edge).
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), din (asynchronous line level),
//        rise/fall (one-cycle pulses relative to the previous synchronized sample).
module n64_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset to the idle-high line level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/n64_response_rx.sv
// Decodes the controller's 32-bit status response plus stop bit from the N64 line by low-time measurement.
// Latency: 3 cycles from a line edge to the decision; valid pulses 3 cycles after the stop-bit rising edge.
// Backpressure: none; arm is ignored while busy, result is a one-cycle valid pulse or sticky err.
// Ports: clk, rst (sync, active-high), arm (start pulse), rx_in (async line level),
//        data (last good response, first bit in MSB), valid, busy, err.
module n64_response_rx
    import n64_pkg::*;
#(
    parameter int BIT_THRESH    = N64_BIT_THRESH,
    parameter int PHASE_TIMEOUT = N64_PHASE_TIMEOUT,
    parameter int START_TIMEOUT = N64_START_TIMEOUT,
    parameter int NUM_BITS      = N64_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                rx_in,
    output logic [NUM_BITS-1:0] data,
    output logic                valid,
    output logic                busy,
    output logic                err
);

    localparam logic [15:0] PHASE_TO = 16'(PHASE_TIMEOUT);
    localparam logic [15:0] START_TO = 16'(START_TIMEOUT);
    localparam logic [5:0]  NUM_B    = 6'(NUM_BITS);
    // The cycle in which the falling edge is detected already has the line low but is
    // not counted (the counter clears there), so the measured low time is phase_cnt + 1.
    // Comparing phase_cnt against BIT_THRESH-1 gives low_time < BIT_THRESH.
    localparam logic [15:0] THRESH_M1 = 16'(BIT_THRESH - 1);

    logic rise;
    logic fall;

    n64_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_in),
        .rise (rise),
        .fall (fall)
    );

    state_t                state;
    logic [15:0]           phase_cnt;
    logic [5:0]            bit_cnt;
    logic [NUM_BITS-1:0]   shreg;

    // Outputs are registered and set on the transition into DONE/ERROR, so they are
    // valid during the single cycle spent in those states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= WAIT_START;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                    end
                end

                WAIT_START: begin
                    if (fall) begin
                        state     <= LOW;
                        phase_cnt <= '0;
                    end else if (phase_cnt >= START_TO) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        phase_cnt <= sat_inc16(phase_cnt);
                    end
                end

                LOW: begin
                    if (rise) begin
                        phase_cnt <= '0;
                        if (bit_cnt < NUM_B) begin
                            shreg   <= {shreg[NUM_BITS-2:0], (phase_cnt < THRESH_M1)};
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= HIGH;
                        end else begin
                            // Low phase that just ended was the stop bit.
                            state <= DONE;
                            data  <= shreg;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else if (phase_cnt >= PHASE_TO) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        phase_cnt <= sat_inc16(phase_cnt);
                    end
                end

                HIGH: begin
                    if (fall) begin
                        state     <= LOW;
                        phase_cnt <= '0;
                    end else if (phase_cnt >= PHASE_TO) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        phase_cnt <= sat_inc16(phase_cnt);
                    end
                end

                DONE:    state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
